// File: rtl/psum_tile_loader.sv
// -----------------------------------------------------------------------------
// psum_tile_loader
//
// PSUM preload engine. A start pulse captures base_addr. The block then reads
// tile_depth consecutive psum vectors from PSUM SRAM and streams them, in
// address order, into the psum L0 FIFO that feeds the MAC array in_n.
//
// SRAM reads are launched against a credit budget of SKID = sram_lat + 1
// slots. A slot is held from the cycle a read is issued until its vector
// leaves the skid buffer. The budget therefore covers every read still in the
// SRAM pipe plus every vector waiting in the skid buffer. When fifo_ready drops,
// reads stop once the slots are exhausted, so no vector is ever lost.
//
// Ports
//   clk         clock
//   reset       asynchronous, active-low reset
//   start       pulse: begin a tile load at base_addr (accepted only when idle)
//   base_addr   first SRAM address of the tile, captured when start is accepted
//   abort       pulse: cancel the current load (no effect when idle)
//   busy        high while a load is in progress
//   done        one-cycle pulse after the last vector has been written
//   err_start   sticky: start seen while busy; cleared by the next accepted start
//   sram_cen    SRAM chip enable, active-low
//   sram_wen    SRAM write enable, active-low; always 1 (read only)
//   sram_addr   SRAM read address
//   sram_q      SRAM read data, valid sram_lat cycles after a read is issued
//   fifo_ready  psum L0 can accept a write this cycle
//   fifo_wr     write strobe to psum L0
//   fifo_data   vector to psum L0
// -----------------------------------------------------------------------------
module psum_tile_loader #(
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int tile_depth = 8,
  parameter int addr_bw    = 11,
  parameter int sram_lat   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err_start,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  input  logic [col*psum_bw-1:0] sram_q,
  input  logic                   fifo_ready,
  output logic                   fifo_wr,
  output logic [col*psum_bw-1:0] fifo_data
);

  localparam int VEC_W  = col * psum_bw;
  localparam int SKID   = sram_lat + 1;
  localparam int CNT_W  = $clog2(tile_depth + 1);
  localparam int PTR_W  = $clog2(SKID);
  localparam int SCNT_W = $clog2(SKID + 1);
  localparam int OCC_W  = $clog2(2 * SKID + 1);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(tile_depth - 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SKID - 1);

  // Load sequencer states.
  localparam logic [1:0] S_IDLE  = 2'd0;  // waiting for start
  localparam logic [1:0] S_LOAD  = 2'd1;  // issuing SRAM reads
  localparam logic [1:0] S_DRAIN = 2'd2;  // all reads issued, writing out the tail
  localparam logic [1:0] S_DONE  = 2'd3;  // one-cycle completion state

  logic [1:0]         state;
  logic [addr_bw-1:0] base_q;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   wr_cnt;

  // One bit per SRAM pipeline stage. vpipe[sram_lat-1] marks the cycle in
  // which sram_q carries the vector of an earlier read.
  logic [sram_lat-1:0] vpipe;

  // Skid buffer: a circular FIFO that absorbs returning read data while the
  // L0 FIFO is stalled.
  logic [VEC_W-1:0]  skid_mem [SKID];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [SCNT_W-1:0] skid_count;

  logic             kill;
  logic             accept;
  logic             issue;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] credit_limit;

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  // When start and abort arrive in the same idle cycle, abort wins and start is
  // dropped.
  assign kill   = abort && (state != S_IDLE);
  assign accept = start && !abort && (state == S_IDLE);

  assign busy = (state != S_IDLE);
  // An abort that lands in the DONE cycle cancels the completion pulse.
  assign done = (state == S_DONE) && !abort;

  assign push = vpipe[sram_lat-1];
  assign pop  = fifo_wr;

  assign fifo_wr   = (skid_count != '0) && fifo_ready && busy;
  assign fifo_data = skid_mem[rd_ptr];

  // Slots in use: reads still inside the SRAM pipe plus vectors held in skid.
  // NOTE: every signal written in an always_comb gets a value before any
  // conditional or loop update. A path that leaves it unassigned would infer
  // a latch.
  always_comb begin
    occupancy = OCC_W'(skid_count);
    for (int i = 0; i < sram_lat; i++) begin
      occupancy = occupancy + OCC_W'(vpipe[i]);
    end
  end

  // A pop in this cycle frees its slot at the same edge the new read claims
  // one. Counting it lets reads issue back to back while fifo_ready is high,
  // and the in-pipe plus skid total still never exceeds SKID.
  assign credit_limit = OCC_W'(SKID) + OCC_W'(pop);
  assign issue        = (state == S_LOAD) && (occupancy < credit_limit);

  assign sram_cen  = !issue;
  assign sram_wen  = 1'b1;
  // Address arithmetic wraps modulo 2^addr_bw.
  assign sram_addr = base_q + addr_bw'(issue_cnt);

  // ---------------------------------------------------------------------------
  // Sequencer, counters and error flag
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every register then
  // updates from values sampled before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      err_start <= 1'b0;
    end else begin
      if (start && (state != S_IDLE)) begin
        err_start <= 1'b1;
      end else if (accept) begin
        err_start <= 1'b0;
      end

      if (kill) begin
        state     <= S_IDLE;
        issue_cnt <= '0;
        wr_cnt    <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   wr_cnt    <= wr_cnt + 1'b1;

        case (state)
          S_IDLE: begin
            if (accept) begin
              state     <= S_LOAD;
              base_q    <= base_addr;
              issue_cnt <= '0;
              wr_cnt    <= '0;
            end
          end
          S_LOAD: begin
            if (issue && (issue_cnt == LAST_IDX)) state <= S_DRAIN;
          end
          S_DRAIN: begin
            // The last write always falls in DRAIN. It needs the last read,
            // and that read moves the sequencer out of LOAD.
            if (pop && (wr_cnt == LAST_IDX)) state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM return pipe and skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: the skid storage is cleared by reset. It holds only SKID entries,
  // and clearing it makes fifo_data a known zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      skid_count <= '0;
      for (int i = 0; i < SKID; i++) begin
        skid_mem[i] <= '0;
      end
    end else if (kill) begin
      // In-flight reads are forgotten and buffered vectors are dropped.
      vpipe      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      skid_count <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < sram_lat; i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      if (push) begin
        skid_mem[wr_ptr] <= sram_q;
        wr_ptr           <= next_slot(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_slot(rd_ptr);
      end

      if (push && !pop) begin
        skid_count <= skid_count + 1'b1;
      end else if (pop && !push) begin
        skid_count <= skid_count - 1'b1;
      end
    end
  end

endmodule
